fetch_sequencer: RTL and testbench

//  Sequences the word-addressed synchronous instruction memory (1-cycle registered read) for the MIPS core.

---
 rtl/fetch_sequencer.sv | 170 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the MIPS core.
// Drives a word-addressed synchronous instruction memory (one-cycle registered read), pairs each
// returned word with the PC it was fetched from and hands it to decode over valid/ready. Decode
// stalls are absorbed by re-issuing the held address so the memory keeps returning the same word.
// Redirects squash the word on the output in the same cycle and issue the target immediately.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       MEM_DEPTH = 8192,
  parameter int unsigned       CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_pc,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] StRun    = 2'd0;
  localparam logic [1:0] StHalted = 2'd1;
  localparam logic [1:0] StFault  = 2'd2;

  // One extra bit so a memory filling the whole address space still compares correctly.
  localparam logic [ADDR_W:0] DepthLimit = (ADDR_W + 1)'(MEM_DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic              resp_vld_q, resp_vld_d;
  logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;
  logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              stall;
  logic              accept;
  logic              issue;
  logic              addr_ok;
  logic [ADDR_W-1:0] addr_inc;

  // Decode-facing outputs; a redirect kills the word on the bus in the same cycle.
  always_comb begin
    out_instr = mem_rdata;
    out_pc    = resp_pc_q;
    out_valid = resp_vld_q & ~redirect;
    stall     = out_valid & ~out_ready;
    accept    = out_valid & out_ready;
    fault     = (state_q == StFault);
    fault_pc  = fault_pc_q;
    fetch_cnt = fetch_cnt_q;
    stall_cnt = stall_cnt_q;
  end

  // Read address selection and whether this cycle launches a fetch.
  always_comb begin
    mem_addr = pc_q;
    issue    = 1'b0;
    unique case (state_q)
      StRun: begin
        issue = 1'b1;
        if (redirect) begin
          mem_addr = redirect_pc;
        end else if (stall) begin
          // Replay the held address so the memory re-presents the same word next cycle.
          mem_addr = resp_pc_q;
        end else begin
          mem_addr = pc_q;
        end
      end
      StHalted: begin
        mem_addr = pc_q;
        issue    = ~redirect & ~halt;
      end
      StFault: begin
        mem_addr = redirect ? redirect_pc : pc_q;
        issue    = redirect;
      end
      default: begin
        mem_addr = pc_q;
        issue    = 1'b0;
      end
    endcase
    addr_ok  = ({1'b0, mem_addr} < DepthLimit);
    addr_inc = mem_addr + ADDR_W'(1);
  end

  // Next-state for the sequencing registers: issue, fault capture, halt entry, halted retarget.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    resp_vld_d = resp_vld_q;
    fault_pc_d = fault_pc_q;

    if (issue) begin
      resp_pc_d = mem_addr;
      pc_d      = addr_inc;
      if (addr_ok) begin
        state_d    = StRun;
        resp_vld_d = 1'b1;
        // Halt only once nothing is pending on the output; the address is parked, not issued.
        if (halt && !stall && !redirect) begin
          state_d    = StHalted;
          resp_vld_d = 1'b0;
          pc_d       = mem_addr;
        end
      end else begin
        state_d    = StFault;
        resp_vld_d = 1'b0;
        fault_pc_d = mem_addr;
      end
    end else if (state_q == StHalted && redirect) begin
      pc_d = redirect_pc;
    end else if (state_q != StRun && state_q != StHalted && state_q != StFault) begin
      // Unused encoding: fall back to a clean stopped state.
      state_d    = StHalted;
      resp_vld_d = 1'b0;
    end
  end

  // Saturating statistics counters.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (accept && !(&fetch_cnt_q)) begin
      fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    end
    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Sequencing state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      resp_vld_q <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      resp_vld_q <= resp_vld_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a stream-level reference model.
// The model tracks which word decode should see next and the run/halt/fault mode; the memory is a
// random-filled array read with one cycle of latency.
module tb_fetch_sequencer;

  localparam int unsigned Depth   = 8192;
  localparam logic [31:0] ResetPc = 32'd0;
  localparam int          MRun    = 0;
  localparam int          MHalt   = 1;
  localparam int          MFault  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_valid;
  logic        out_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  logic [31:0] mem [Depth];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int          m_mode;
  bit          m_shown;
  logic [31:0] m_cur;
  logic [31:0] m_nxt;
  logic [31:0] m_fpc;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;

  fetch_sequencer #(
    .ADDR_W   (32),
    .RESET_PC (ResetPc),
    .MEM_DEPTH(Depth),
    .CNT_W    (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .fault      (fault),
    .fault_pc   (fault_pc),
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_addr < Depth) mem_rdata <= mem[mem_addr[12:0]];
    else                  mem_rdata <= 32'hBAD0_0000 ^ mem_addr;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = MRun;
    m_shown = 1'b0;
    m_cur   = ResetPc;
    m_nxt   = ResetPc;
    m_fpc   = 32'd0;
    m_fetch = 32'd0;
    m_stall = 32'd0;
  endtask

  // Start presenting address a to decode, or fault if it is outside the memory.
  task automatic present(input logic [31:0] a);
    if (a < Depth) begin
      m_shown = 1'b1;
      m_cur   = a;
      m_nxt   = a + 32'd1;
    end else begin
      m_mode  = MFault;
      m_shown = 1'b0;
      m_fpc   = a;
    end
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_update();
    bit vis;
    vis = m_shown & ~redirect;
    if (vis && out_ready && m_fetch != '1)  m_fetch = m_fetch + 32'd1;
    if (vis && !out_ready && m_stall != '1) m_stall = m_stall + 32'd1;
    case (m_mode)
      MRun: begin
        if (redirect)                    present(redirect_pc);
        else if (vis && !out_ready)      m_shown = 1'b1;  // word held for decode
        else if (halt && m_nxt < Depth) begin
          m_mode  = MHalt;
          m_shown = 1'b0;
        end else                         present(m_nxt);
      end
      MHalt: begin
        if (redirect) m_nxt = redirect_pc;
        else if (!halt) begin
          m_mode = MRun;
          present(m_nxt);
        end
      end
      default: begin
        if (redirect) begin
          m_mode = MRun;
          present(redirect_pc);
        end
      end
    endcase
  endtask

  task automatic check_outputs();
    bit vis;
    vis = m_shown & ~redirect;
    check("out_valid", 64'(out_valid), 64'(vis));
    if (vis) begin
      check("out_pc", 64'(out_pc), 64'(m_cur));
      check("out_instr", 64'(out_instr), 64'(mem[m_cur[12:0]]));
    end
    check("fault", 64'(fault), 64'(m_mode == MFault));
    check("fault_pc", 64'(fault_pc), 64'(m_fpc));
    check("fetch_cnt", 64'(fetch_cnt), 64'(m_fetch));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
  endtask

  task automatic reset_checks();
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_pc", 64'(out_pc), 64'(ResetPc));
    check("rst_mem_addr", 64'(mem_addr), 64'(ResetPc));
    check("rst_fault", 64'(fault), 64'(0));
    check("rst_fault_pc", 64'(fault_pc), 64'(0));
    check("rst_fetch_cnt", 64'(fetch_cnt), 64'(0));
    check("rst_stall_cnt", 64'(stall_cnt), 64'(0));
  endtask

  // One cycle: apply inputs at the falling edge, check, then follow the rising edge in the model.
  // exp_pc >= 0 additionally requires that exact PC to be on the output this cycle.
  task automatic step(input logic r, input logic [31:0] rp, input logic h, input logic rdy,
                      input int exp_pc);
    @(negedge clk);
    redirect    = r;
    redirect_pc = rp;
    halt        = h;
    out_ready   = rdy;
    #1;
    check_outputs();
    if (exp_pc >= 0) begin
      check("dir_valid", 64'(out_valid), 64'(1));
      check("dir_pc", 64'(out_pc), 64'(exp_pc));
    end
    @(posedge clk);
    model_update();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    redirect  = 1'b0;
    halt      = 1'b0;
    out_ready = 1'b1;
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
  endtask

  // Assert reset between clock edges, check that outputs clear at once, then release.
  task automatic async_reset();
    @(negedge clk);
    #3;
    redirect = 1'b0;
    halt     = 1'b0;
    rst_n    = 1'b0;
    #1;
    reset_checks();
    model_reset();
    repeat (2) @(negedge clk);
    release_reset();
  endtask

  initial begin
    logic        h_r;
    logic        r;
    logic [31:0] rp;
    int          sel;

    for (int i = 0; i < Depth; i++) mem[i] = $urandom;
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    halt        = 1'b0;
    out_ready   = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    reset_checks();
    model_reset();
    release_reset();

    // Back-to-back from reset.
    for (int k = 0; k < 5; k++) step(1'b0, 32'd0, 1'b0, 1'b1, k);
    // Stall on PC 5, then continue without gap or duplicate.
    for (int k = 0; k < 3; k++) step(1'b0, 32'd0, 1'b0, 1'b0, 5);
    for (int k = 5; k < 9; k++) step(1'b0, 32'd0, 1'b0, 1'b1, k);
    // Redirect while PC 9 is on the output, then redirect during a stall.
    step(1'b1, 32'h100, 1'b0, 1'b1, -1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 'h100);
    step(1'b0, 32'd0, 1'b0, 1'b0, 'h101);
    step(1'b1, 32'h200, 1'b0, 1'b0, -1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 'h200);
    // Halt on 0x20, release after four cycles, then retarget while halted.
    step(1'b1, 32'h20, 1'b0, 1'b1, -1);
    step(1'b0, 32'd0, 1'b1, 1'b1, 'h20);
    for (int k = 0; k < 3; k++) step(1'b0, 32'd0, 1'b1, 1'b1, -1);
    step(1'b0, 32'd0, 1'b0, 1'b1, -1);
    step(1'b0, 32'd0, 1'b1, 1'b1, 'h21);
    step(1'b1, 32'h40, 1'b1, 1'b1, -1);
    step(1'b0, 32'd0, 1'b1, 1'b1, -1);
    step(1'b0, 32'd0, 1'b0, 1'b1, -1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 'h40);
    // Run off the end of memory, stay faulted on a bad target, recover on a good one.
    step(1'b1, 32'd8191, 1'b0, 1'b1, -1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 8191);
    step(1'b0, 32'd0, 1'b0, 1'b1, -1);
    step(1'b1, 32'd9000, 1'b0, 1'b1, -1);
    step(1'b0, 32'd0, 1'b0, 1'b1, -1);
    step(1'b1, 32'h10, 1'b0, 1'b1, -1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 'h10);
    // Asynchronous reset while stalled.
    step(1'b0, 32'd0, 1'b0, 1'b0, 'h11);
    step(1'b0, 32'd0, 1'b0, 1'b0, 'h11);
    async_reset();
    step(1'b0, 32'd0, 1'b0, 1'b1, 0);

    // Random traffic.
    h_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 7) == 0);
      sel = int'($urandom_range(0, 19));
      if (sel < 14)      rp = $urandom_range(0, Depth - 1);
      else if (sel < 17) rp = $urandom_range(Depth - 8, Depth - 1);
      else               rp = $urandom_range(Depth, Depth + 500);
      if ($urandom_range(0, 11) == 0) h_r = ~h_r;
      step(r, rp, h_r, ($urandom_range(0, 3) != 0), -1);
      if ($urandom_range(0, 699) == 0) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
